// File: rtl/if_stage_fq_pkg.sv
// rtl/if_stage_fq_pkg.sv - shared widths, defaults and sizing helpers for the fetch stage
package if_stage_fq_pkg;

  localparam int          DEF_XLEN            = 32;
  localparam int          DEF_INST_LEN        = 32;
  localparam int          DEF_FQ_DEPTH        = 4;
  localparam int          DEF_MAX_OUTSTANDING = 2;
  localparam logic [31:0] DEF_RESET_PC        = 32'hbfc00000;
  localparam int          INST_BYTES          = 4;

  function automatic int br_bus_wd(input int xlen);
    return xlen + 1;
  endfunction

  function automatic int fs_to_ds_bus_wd(input int xlen, input int inst_len);
    return xlen + inst_len;
  endfunction

  // Bits needed to hold a count in 0..max_val inclusive.
  function automatic int cnt_wd(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/if_stage_fq_gnrl_sync_fifo.sv
// rtl/if_stage_fq_gnrl_sync_fifo.sv - pointer-based sync FIFO with clear and occupancy outputs
module if_stage_fq_gnrl_sync_fifo
  import if_stage_fq_pkg::*;
#(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = cnt_wd(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage_fq.sv
// rtl/if_stage_fq.sv - instruction fetch stage with split-transaction port and fetch queue
module if_stage_fq
  import if_stage_fq_pkg::*;
#(
  parameter int               XLEN            = DEF_XLEN,
  parameter int               INST_LEN        = DEF_INST_LEN,
  parameter int               FQ_DEPTH        = DEF_FQ_DEPTH,
  parameter int               MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(DEF_RESET_PC),
  localparam int              BR_BUS_WD       = br_bus_wd(XLEN),
  localparam int              FS_TO_DS_BUS_WD = fs_to_ds_bus_wd(XLEN, INST_LEN)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       inst_req,
  output logic [XLEN-1:0]            inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [INST_LEN-1:0]        inst_rdata,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

  localparam int OW = cnt_wd(MAX_OUTSTANDING);
  localparam int CW = cnt_wd(FQ_DEPTH);
  localparam int SW = cnt_wd(FQ_DEPTH + MAX_OUTSTANDING);

  logic            br_taken;
  logic [XLEN-1:0] br_target;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_nxt;
  logic [OW-1:0]   discard;
  logic [OW-1:0]   discard_nxt;

  logic            accept;
  logic            resp;
  logic            resp_drop;
  logic [SW-1:0]   slots_used;

  logic            fq_push;
  logic            fq_pop;
  logic            fq_full;
  logic            fq_empty;
  logic [CW-1:0]   fq_count;

  logic [XLEN-1:0] pf_pc;
  logic            pf_full;
  logic            pf_empty;
  logic [OW-1:0]   pf_count;

  assign {br_taken, br_target} = br_bus;

  // Every in-flight request owns a queue slot, so a response can always be stored.
  assign slots_used = SW'(fq_count) + SW'(outstanding);
  assign inst_req   = reset && !br_taken
                   && (outstanding < OW'(MAX_OUTSTANDING))
                   && (slots_used < SW'(FQ_DEPTH));
  assign inst_addr  = fetch_pc;

  assign accept    = inst_req && inst_addr_ok;
  assign resp      = inst_data_ok;
  assign resp_drop = resp && (discard != '0);

  assign fs_to_ds_valid = !fq_empty;
  assign fq_pop         = fs_to_ds_valid && ds_allowin;
  assign fq_push        = resp && !resp_drop && !br_taken;

  always_comb begin
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    fetch_pc_nxt    = fetch_pc;

    if (accept && !resp)      outstanding_nxt = outstanding + OW'(1);
    else if (!accept && resp) outstanding_nxt = outstanding - OW'(1);

    // Requests still in flight after a redirect belong to the old path.
    // Earlier discards are still counted in outstanding, so this accumulates.
    if (br_taken)       discard_nxt = resp ? outstanding - OW'(1) : outstanding;
    else if (resp_drop) discard_nxt = discard - OW'(1);

    if (br_taken)    fetch_pc_nxt = br_target;
    else if (accept) fetch_pc_nxt = fetch_pc + XLEN'(INST_BYTES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // In-flight pc FIFO: pairs each response with the address that produced it.
  if_stage_fq_gnrl_sync_fifo #(
    .DW    (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp),
    .pop_data  (pf_pc),
    .full      (pf_full),
    .empty     (pf_empty),
    .count     (pf_count)
  );

  if_stage_fq_gnrl_sync_fifo #(
    .DW    (FS_TO_DS_BUS_WD),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (br_taken),
    .push      (fq_push),
    .push_data ({pf_pc, inst_rdata}),
    .pop       (fq_pop),
    .pop_data  (fs_to_ds_bus),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!reset)
    inst_data_ok |-> (outstanding != '0));
  a_target_aligned: assert property (@(posedge clk) disable iff (!reset)
    br_taken |-> (br_target[1:0] == 2'b00));
  a_fq_room: assert property (@(posedge clk) disable iff (!reset)
    fq_push |-> (!fq_full || fq_pop));
  a_pf_room: assert property (@(posedge clk) disable iff (!reset)
    accept |-> (!pf_full || resp));
  a_pf_tracks: assert property (@(posedge clk) disable iff (!reset)
    (pf_count == outstanding) && (pf_empty == (outstanding == '0)));

endmodule

// File: tb/tb_if_stage_fq.sv
// tb/tb_if_stage_fq.sv - scoreboard bench for if_stage_fq with a split-transaction memory model
module tb_if_stage_fq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;

  bit          resp_en = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] sb_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  if_stage_fq dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hdead_beef;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  // Memory model and scoreboard monitor: inputs are set at the falling edge,
  // the response is chosen at +1, and the coming rising edge is predicted at +2.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      pend.delete();
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
    end else begin
      inst_data_ok = resp_en && (pend.size() > 0);
      inst_rdata   = inst_data_ok ? mem_word(pend[0]) : 32'h0;
      #1;
      if (fs_to_ds_valid && ds_allowin) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: delivered %h while nothing expected", fs_to_ds_bus);
        end else begin
          sb_pc = exp_q.pop_front();
          check("sb_deliver", fs_to_ds_bus, {sb_pc, mem_word(sb_pc)});
        end
      end
      if (inst_data_ok) pend.delete(0);
      if (inst_req && inst_addr_ok) pend.push_back(inst_addr);
    end
  end

  initial begin
    reset = 1'b0; ds_allowin = 1'b1; inst_addr_ok = 1'b1; resp_en = 1'b1; br_bus = '0;
    step(2); settle();
    check("rst_inst_req", inst_req, 0);
    check("rst_fs_valid", fs_to_ds_valid, 0);

    // Streaming from reset: one pc per cycle, first delivery two cycles after accept.
    for (int i = 0; i < 8; i++) expect_pc(32'hbfc00000 + 32'(4 * i));
    step(1); reset = 1'b1;
    step(1); settle();
    check("t1_valid_after_accept", fs_to_ds_valid, 0);
    check("t1_first_addr", inst_addr, 32'hbfc00004);
    step(1); settle();
    check("t1_valid_t2", fs_to_ds_valid, 1);
    check("t1_head_pc_t2", fs_to_ds_bus[63:32], 32'hbfc00000);
    step(6); inst_addr_ok = 1'b0;
    step(4); settle();
    check("t1_drained", exp_q.size(), 0);
    check("t1_next_addr", inst_addr, 32'hbfc00020);

    // Decode stalled: queue fills and issue stops, then drains in order.
    for (int i = 0; i < 4; i++) expect_pc(32'hbfc00020 + 32'(4 * i));
    step(1); ds_allowin = 1'b0; inst_addr_ok = 1'b1;
    step(8); settle();
    check("t2_req_stopped", inst_req, 0);
    check("t2_full_valid", fs_to_ds_valid, 1);
    check("t2_head", fs_to_ds_bus, {32'hbfc00020, mem_word(32'hbfc00020)});
    step(1); ds_allowin = 1'b1; inst_addr_ok = 1'b0;
    step(1); settle();
    check("t2_req_resumes", inst_req, 1);
    step(5); settle();
    check("t2_drained", exp_q.size(), 0);

    // Redirect with two in flight and one queued, none delivered.
    expect_pc(32'h80001000);
    step(1); ds_allowin = 1'b0; resp_en = 1'b0; inst_addr_ok = 1'b1;
    step(2); resp_en = 1'b1;
    step(1); resp_en = 1'b0;
    step(1); br_bus = {1'b1, 32'h80001000}; resp_en = 1'b1; settle();
    check("t3_req_forced_low", inst_req, 0);
    check("t3_queue_holds_one", fs_to_ds_valid, 1);
    step(1); br_bus = '0; ds_allowin = 1'b1; settle();
    check("t3_flushed", fs_to_ds_valid, 0);
    check("t3_target_addr", inst_addr, 32'h80001000);
    step(1); inst_addr_ok = 1'b0; settle();
    check("t3_late_rsp_dropped", fs_to_ds_valid, 0);
    step(3); settle();
    check("t3_drained", exp_q.size(), 0);

    // Redirect in the cycle decode pops the head: head delivered once, rest flushed.
    expect_pc(32'h80001004);
    expect_pc(32'h80002000);
    step(1); ds_allowin = 1'b0; inst_addr_ok = 1'b1; resp_en = 1'b1;
    step(4); ds_allowin = 1'b1; br_bus = {1'b1, 32'h80002000}; settle();
    check("t4_head_pc", fs_to_ds_bus[63:32], 32'h80001004);
    step(1); br_bus = '0; settle();
    check("t4_nothing_after_head", fs_to_ds_valid, 0);
    check("t4_target_addr", inst_addr, 32'h80002000);
    step(1); inst_addr_ok = 1'b0;
    step(3); settle();
    check("t4_drained", exp_q.size(), 0);

    // Address back-pressure holds the request, redirect switches it.
    expect_pc(32'h80003000);
    for (int i = 0; i < 5; i++) begin
      step(1); settle();
      check("t5_stall_addr", inst_addr, 32'h80002004);
      check("t5_stall_req", inst_req, 1);
    end
    step(1); br_bus = {1'b1, 32'h80003000}; settle();
    check("t5_br_req_low", inst_req, 0);
    step(1); br_bus = '0; inst_addr_ok = 1'b1; settle();
    check("t5_switched_addr", inst_addr, 32'h80003000);
    check("t5_switched_req", inst_req, 1);
    step(1); inst_addr_ok = 1'b0;
    step(3); settle();
    check("t5_drained", exp_q.size(), 0);

    // Reset with two outstanding and two queued.
    step(1); ds_allowin = 1'b0; resp_en = 1'b1; inst_addr_ok = 1'b1;
    step(2); resp_en = 1'b0;
    step(1); resp_en = 1'b1;
    step(1); resp_en = 1'b0; settle();
    check("t6_loaded_valid", fs_to_ds_valid, 1);
    check("t6_loaded_req", inst_req, 1);
    step(1); reset = 1'b0; settle();
    check("t6_rst_req", inst_req, 0);
    check("t6_rst_valid", fs_to_ds_valid, 0);
    expect_pc(32'hbfc00000);
    step(2); reset = 1'b1; ds_allowin = 1'b1; resp_en = 1'b1; inst_addr_ok = 1'b1; settle();
    check("t6_restart_addr", inst_addr, 32'hbfc00000);
    check("t6_restart_req", inst_req, 1);
    step(1); inst_addr_ok = 1'b0;
    step(4); settle();
    check("t6_drained", exp_q.size(), 0);

    // Back-to-back redirects: last target wins, both old responses dropped.
    expect_pc(32'h80005000);
    step(1); resp_en = 1'b0; inst_addr_ok = 1'b1; ds_allowin = 1'b1;
    step(2); br_bus = {1'b1, 32'h80004000};
    step(1); br_bus = {1'b1, 32'h80005000}; resp_en = 1'b1;
    step(1); br_bus = '0; settle();
    check("t7_last_target", inst_addr, 32'h80005000);
    check("t7_no_valid", fs_to_ds_valid, 0);
    step(1); inst_addr_ok = 1'b0; settle();
    check("t7_old_dropped", fs_to_ds_valid, 0);
    step(3); settle();
    check("t7_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
